// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_hazard_ctrl: stall/flush controller for the 5-stage RV32 pipeline.   |
// | Optional PIPE_CTRL_PERF_EN builds the stall/flush counters. Rev 1.0       |
// +--------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 4,
  parameter int MDU_TIMEOUT  = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_redirect,
  input  logic        ex_mdu_start,
  input  logic        mdu_done,
  input  logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_pause,
  output logic        if_id_pause,
  output logic        if_id_bubble,
  output logic        id_ex_pause,
  output logic        id_ex_bubble,
  output logic        ex_mem_pause,
  output logic        ex_mem_bubble,
  output logic        mem_wb_pause,
  output logic        mem_wb_bubble,
  output logic        mdu_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_FLUSH    = 2'd0,
    ST_RUN      = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);
  localparam logic [7:0] WDOG_LAST  = 8'(MDU_TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] flush_ctr;
  logic [7:0] wdog;
  logic [7:0] wdog_next;
  logic       timeout_flag;
  logic       timeout_set;

  logic dmem_freeze;
  logic load_use;
  logic pc_p, ifid_p, ifid_b, idex_p, idex_b, exmem_p, exmem_b, memwb_p, memwb_b;

  assign dmem_freeze = dmem_req & ~dmem_ready;
  assign load_use    = ex_is_load & (ex_rd != 5'd0) &
                       ((id_rs1_used & (id_rs1 == ex_rd)) |
                        (id_rs2_used & (id_rs2 == ex_rd)));

  always_comb begin
    state_next  = state;
    wdog_next   = wdog;
    timeout_set = 1'b0;
    pc_p    = 1'b0;
    ifid_p  = 1'b0;
    ifid_b  = 1'b0;
    idex_p  = 1'b0;
    idex_b  = 1'b0;
    exmem_p = 1'b0;
    exmem_b = 1'b0;
    memwb_p = 1'b0;
    memwb_b = 1'b0;

    unique case (state)
      ST_FLUSH: begin
        pc_p    = 1'b1;
        ifid_b  = 1'b1;
        idex_b  = 1'b1;
        exmem_b = 1'b1;
        memwb_b = 1'b1;
        if (flush_ctr <= 4'd1) state_next = ST_RUN;
      end

      ST_RUN: begin
        if (dmem_freeze) begin
          pc_p    = 1'b1;
          ifid_p  = 1'b1;
          idex_p  = 1'b1;
          exmem_p = 1'b1;
          memwb_b = 1'b1;
        end else if (ex_redirect) begin
          // The squashed ID instruction must not raise a load-use stall.
          ifid_b = 1'b1;
          idex_b = 1'b1;
        end else if (ex_mdu_start & ~mdu_done) begin
          pc_p       = 1'b1;
          ifid_p     = 1'b1;
          idex_p     = 1'b1;
          exmem_b    = 1'b1;
          state_next = ST_MDU_WAIT;
          wdog_next  = 8'd0;
        end else if (load_use) begin
          pc_p   = 1'b1;
          ifid_p = 1'b1;
          idex_b = 1'b1;
        end else if (~imem_ready) begin
          pc_p   = 1'b1;
          ifid_b = 1'b1;
        end
      end

      ST_MDU_WAIT: begin
        if (dmem_freeze) begin
          pc_p    = 1'b1;
          ifid_p  = 1'b1;
          idex_p  = 1'b1;
          exmem_p = 1'b1;
          memwb_b = 1'b1;
        end else if (mdu_done) begin
          state_next = ST_RUN;
        end else if (wdog == WDOG_LAST) begin
          // Watchdog expiry releases the pipeline exactly like a done cycle.
          timeout_set = 1'b1;
          state_next  = ST_RUN;
        end else begin
          pc_p      = 1'b1;
          ifid_p    = 1'b1;
          idex_p    = 1'b1;
          exmem_b   = 1'b1;
          wdog_next = wdog + 8'd1;
        end
      end

      default: state_next = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_FLUSH;
      flush_ctr    <= FLUSH_INIT;
      wdog         <= 8'd0;
      timeout_flag <= 1'b0;
    end else begin
      state <= state_next;
      wdog  <= wdog_next;
      if ((state == ST_FLUSH) && (flush_ctr != 4'd0)) flush_ctr <= flush_ctr - 4'd1;
      if (timeout_set) timeout_flag <= 1'b1;
    end
  end

  // A held register cannot also take a bubble: pause wins.
  assign pc_pause      = pc_p;
  assign if_id_pause   = ifid_p;
  assign if_id_bubble  = ifid_b & ~ifid_p;
  assign id_ex_pause   = idex_p;
  assign id_ex_bubble  = idex_b & ~idex_p;
  assign ex_mem_pause  = exmem_p;
  assign ex_mem_bubble = exmem_b & ~exmem_p;
  assign mem_wb_pause  = memwb_p;
  assign mem_wb_bubble = memwb_b & ~memwb_p;
  assign mdu_timeout   = timeout_flag;

`ifdef PIPE_CTRL_PERF_EN
  logic        redirect_taken;
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  assign redirect_taken = (state == ST_RUN) & ~dmem_freeze & ex_redirect;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (pc_p && (state != ST_FLUSH)) stall_q <= stall_q + 32'd1;
      if (redirect_taken) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a random run
// against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int FC = 4;
  localparam int MT = 8;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [8:0] CTL_FLUSH  = 9'b101010101;
  localparam logic [8:0] CTL_FREEZE = 9'b110101001;
  localparam logic [8:0] CTL_REDIR  = 9'b001010000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_is_load, ex_redirect, ex_mdu_start;
  logic        mdu_done, imem_ready, dmem_req, dmem_ready;
  logic        pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble;
  logic        ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble, mdu_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  logic [8:0]  ctl_obs;
  logic [64:0] regs_obs;
  assign ctl_obs  = {pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble,
                     ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble};
  assign regs_obs = {mdu_timeout, stall_cnt, flush_cnt};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, kept in terms of the rules rather than the FSM.
  int          m_flush_left;
  bit          m_busy;
  int          m_wait;
  bit          m_timeout;
  logic [31:0] m_stalls;
  logic [31:0] m_flushes;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MDU_TIMEOUT(MT)) dut (
    .clock(clock), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_pause(pc_pause), .if_id_pause(if_id_pause), .if_id_bubble(if_id_bubble),
    .id_ex_pause(id_ex_pause), .id_ex_bubble(id_ex_bubble),
    .ex_mem_pause(ex_mem_pause), .ex_mem_bubble(ex_mem_bubble),
    .mem_wb_pause(mem_wb_pause), .mem_wb_bubble(mem_wb_bubble),
    .mdu_timeout(mdu_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic model_reset();
    m_flush_left = FC;
    m_busy       = 1'b0;
    m_wait       = 0;
    m_timeout    = 1'b0;
    m_stalls     = 32'd0;
    m_flushes    = 32'd0;
  endtask

  function automatic logic [8:0] model_ctl();
    logic pc, ip, ib, dp, db, ep, eb, mp, mb;
    {pc, ip, ib, dp, db, ep, eb, mp, mb} = 9'b0;
    if (!reset_n || m_flush_left > 0) begin
      pc = 1; ib = 1; db = 1; eb = 1; mb = 1;
    end else if (dmem_req && !dmem_ready) begin
      pc = 1; ip = 1; dp = 1; ep = 1; mb = 1;
    end else if (m_busy) begin
      if (!mdu_done && m_wait != MT - 1) begin
        pc = 1; ip = 1; dp = 1; eb = 1;
      end
    end else if (ex_redirect) begin
      ib = 1; db = 1;
    end else if (ex_mdu_start && !mdu_done) begin
      pc = 1; ip = 1; dp = 1; eb = 1;
    end else if (ex_is_load && ex_rd != 0 &&
                 ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd))) begin
      pc = 1; ip = 1; db = 1;
    end else if (!imem_ready) begin
      pc = 1; ib = 1;
    end
    return {pc, ip, ib, dp, db, ep, eb, mp, mb};
  endfunction

  function automatic logic [64:0] model_regs();
    return {m_timeout, PERF ? m_stalls : 32'd0, PERF ? m_flushes : 32'd0};
  endfunction

  // Applies one clock edge to the model using the inputs of the ending cycle.
  task automatic model_step(input logic [8:0] ctl);
    if (!reset_n) begin
      model_reset();
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else begin
      if (ctl[8]) m_stalls++;
      if (!(dmem_req && !dmem_ready)) begin
        if (m_busy) begin
          if (mdu_done) m_busy = 1'b0;
          else if (m_wait == MT - 1) begin
            m_busy = 1'b0;
            m_timeout = 1'b1;
          end else m_wait++;
        end else if (ex_redirect) begin
          m_flushes++;
        end else if (ex_mdu_start && !mdu_done) begin
          m_busy = 1'b1;
          m_wait = 0;
        end
      end
    end
  endtask

  task automatic advance(input logic [8:0] ctl);
    @(posedge clock);
    model_step(ctl);
    #1;
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_is_load = 1'b0;
    ex_redirect = 1'b0; ex_mdu_start = 1'b0; mdu_done = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic rand_inputs();
    id_rs1 = 5'($urandom_range(0, 3));
    id_rs2 = 5'($urandom_range(0, 3));
    ex_rd  = 5'($urandom_range(0, 3));
    id_rs1_used  = 1'($urandom_range(0, 1));
    id_rs2_used  = 1'($urandom_range(0, 1));
    ex_is_load   = ($urandom_range(0, 2) == 0);
    ex_redirect  = ($urandom_range(0, 5) == 0);
    ex_mdu_start = ($urandom_range(0, 9) == 0);
    mdu_done     = ($urandom_range(0, 4) == 0);
    imem_ready   = ($urandom_range(0, 3) != 0);
    dmem_req     = ($urandom_range(0, 3) == 0);
    dmem_ready   = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    logic [8:0] e;
    reset_n = 1'b0;
    model_reset();
    set_idle();
    #1;
    n_tests++;
    if (ctl_obs !== CTL_FLUSH || regs_obs !== 65'd0) begin
      n_fail++;
      $display("FAIL reset_state: ctl=%b regs=%h want ctl=%b regs=0", ctl_obs, regs_obs, CTL_FLUSH);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int c = 0; c < FC + 2; c++) begin
      if (c < FC) rand_inputs(); else set_idle();
      #2;
      e = model_ctl();
      n_tests++;
      if (ctl_obs !== e || (c < FC) !== (ctl_obs == CTL_FLUSH)) begin
        n_fail++;
        $display("FAIL reset_drain c=%0d: ctl=%b want %b", c, ctl_obs, e);
      end
      advance(e);
    end
    n_tests++;
    if (regs_obs !== model_regs() || stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_drain_regs: got %h want %h", regs_obs, model_regs());
    end
  endtask

  task automatic test_load_use();
    // {ex_rd, rs1, rs1_used, rs2, rs2_used, stall_expected}
    logic [17:0] tbl [4] = '{{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1},
                             {5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0},
                             {5'd7, 5'd7, 1'b1, 5'd3, 1'b0, 1'b1},
                             {5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0}};
    logic [8:0] e;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 2; c++) begin
        set_idle();
        if (c == 0) begin
          ex_is_load = 1'b1;
          {ex_rd, id_rs1, id_rs1_used, id_rs2, id_rs2_used} = tbl[i][17:1];
        end
        #2;
        e = model_ctl();
        n_tests++;
        if (ctl_obs !== e ||
            {pc_pause, if_id_pause, id_ex_bubble} !== {3{(c == 0) & tbl[i][0]}}) begin
          n_fail++;
          $display("FAIL load_use i=%0d c=%0d: ctl=%b want %b", i, c, ctl_obs, e);
        end
        advance(e);
      end
    end
    n_tests++;
    if (regs_obs !== model_regs()) begin
      n_fail++;
      $display("FAIL load_use_regs: got %h want %h", regs_obs, model_regs());
    end
  endtask

  task automatic test_redirect_vs_load();
    logic [8:0] e;
    set_idle();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    ex_redirect = 1'b1; imem_ready = 1'b0;
    #2;
    e = model_ctl();
    n_tests++;
    if (ctl_obs !== e || ctl_obs !== CTL_REDIR) begin
      n_fail++;
      $display("FAIL redirect_vs_load: ctl=%b want %b", ctl_obs, CTL_REDIR);
    end
    advance(e);
    n_tests++;
    if (regs_obs !== model_regs() || flush_cnt !== 32'(PERF)) begin
      n_fail++;
      $display("FAIL redirect_count: got %h want %h", regs_obs, model_regs());
    end
  endtask

  task automatic test_dmem_in_mdu();
    logic [8:0] e;
    int stalls = 0;
    int frz = 0;
    for (int c = 0; c < 20; c++) begin
      set_idle();
      if (c == 0) ex_mdu_start = 1'b1;
      if (c >= 3 && c <= 5) dmem_req = 1'b1;
      if (c >= 3 && c <= 5) dmem_ready = 1'b0;
      #2;
      e = model_ctl();
      n_tests++;
      if (ctl_obs !== e || ((c >= 3 && c <= 5) && ctl_obs !== CTL_FREEZE)) begin
        n_fail++;
        $display("FAIL dmem_in_mdu c=%0d: ctl=%b want %b", c, ctl_obs, e);
      end
      stalls += int'(pc_pause);
      frz += int'(mem_wb_bubble);
      advance(e);
    end
    n_tests++;
    if (stalls != MT + 3 || frz != 3 || mdu_timeout !== 1'b1 || regs_obs !== model_regs()) begin
      n_fail++;
      $display("FAIL dmem_in_mdu_totals: stalls=%0d freeze=%0d to=%b want %0d 3 1",
               stalls, frz, mdu_timeout, MT + 3);
    end
  endtask

  task automatic test_mdu();
    logic [8:0] e;
    int stalls = 0;
    int bub = 0;
    for (int c = 0; c < 8; c++) begin
      set_idle();
      if (c == 0) ex_mdu_start = 1'b1;
      if (c == 5) mdu_done = 1'b1;
      #2;
      e = model_ctl();
      n_tests++;
      if (ctl_obs !== e || ((c == 5) && ctl_obs !== 9'd0)) begin
        n_fail++;
        $display("FAIL mdu_done c=%0d: ctl=%b want %b", c, ctl_obs, e);
      end
      stalls += int'(pc_pause);
      bub += int'(ex_mem_bubble);
      advance(e);
    end
    n_tests++;
    if (stalls != 5 || bub != 5) begin
      n_fail++;
      $display("FAIL mdu_cost: stalls=%0d bubbles=%0d want 5 5", stalls, bub);
    end
    stalls = 0;
    for (int c = 0; c < 14; c++) begin
      set_idle();
      if (c == 0 || c == 12) ex_mdu_start = 1'b1;
      if (c == 12) mdu_done = 1'b1;
      #2;
      e = model_ctl();
      n_tests++;
      if (ctl_obs !== e) begin
        n_fail++;
        $display("FAIL mdu_timeout c=%0d: ctl=%b want %b", c, ctl_obs, e);
      end
      stalls += int'(pc_pause);
      advance(e);
    end
    n_tests++;
    if (stalls != MT || mdu_timeout !== 1'b1 || regs_obs !== model_regs()) begin
      n_fail++;
      $display("FAIL mdu_timeout_totals: stalls=%0d to=%b want %0d 1", stalls, mdu_timeout, MT);
    end
  endtask

  task automatic test_reset_mid_mdu();
    logic [8:0] e;
    for (int c = 0; c < 5; c++) begin
      set_idle();
      if (c == 0) ex_mdu_start = 1'b1;
      if (c == 4) dmem_req = 1'b1;
      if (c == 4) dmem_ready = 1'b0;
      #2;
      e = model_ctl();
      n_tests++;
      if (ctl_obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid_mdu_pre c=%0d: ctl=%b want %b", c, ctl_obs, e);
      end
      if (c < 4) advance(e);
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (ctl_obs !== CTL_FLUSH || regs_obs !== 65'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mdu: ctl=%b regs=%h want %b 0", ctl_obs, regs_obs, CTL_FLUSH);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int c = 0; c < FC + 2; c++) begin
      set_idle();
      #2;
      e = model_ctl();
      n_tests++;
      if (ctl_obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid_mdu_drain c=%0d: ctl=%b want %b", c, ctl_obs, e);
      end
      advance(e);
    end
  endtask

  task automatic test_random();
    logic [8:0] e;
    int bad = 0;
    for (int c = 0; c < 1500; c++) begin
      rand_inputs();
      reset_n = ($urandom_range(0, 299) != 0);
      if (!reset_n) model_reset();
      #2;
      e = model_ctl();
      n_tests++;
      if (ctl_obs !== e) begin
        n_fail++;
        bad++;
        if (bad < 10) $display("FAIL random_ctl c=%0d: ctl=%b want %b", c, ctl_obs, e);
      end
      advance(e);
      n_tests++;
      if (regs_obs !== model_regs()) begin
        n_fail++;
        bad++;
        if (bad < 10) $display("FAIL random_regs c=%0d: got %h want %h", c, regs_obs, model_regs());
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect_vs_load();
    test_dmem_in_mdu();
    test_mdu();
    test_reset_mid_mdu();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: bench did not complete");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
